// File: rtl/neuron_mac_q10_22.sv
// ---------------------------------------------------------------------------
// neuron_mac_q10_22
//
// Serial multiply-accumulate for one neuron:
//   result = bias + sum_{i=0}^{N_INPUTS-1} x_i * w_i
// The operands are signed Q4.12 activations and signed Q6.10 weights. Their
// product is exactly Q10.22, so the product needs no shift and no rounding.
// The result is a signed Q10.22 32-bit value. It feeds the fp16 tanh stage.
//
// Pipeline: an accepted pair is multiplied into prod_reg on the accepting
// edge. prod_reg is added into the accumulator on the following edge. The
// edge that adds the final product also moves the FSM to DONE and raises
// out_valid.
//
// Optional feature (macro MAC_SAT_EN):
//   defined   - on overflow the accumulator saturates to 0x7FFFFFFF or
//               0x80000000, and later terms add onto the saturated value.
//   undefined - two's-complement wrap (low 32 bits of the sum).
//   In both builds the sticky ovf flag records the overflow.
//
// Parameters:
//   N_INPUTS  operand pairs per neuron (1..65535)
//   CNT_W     operand counter width, 2**CNT_W > N_INPUTS
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a neuron; bias is sampled with it
//   bias       signed Q10.22 initial accumulator value
//   x_in       signed Q4.12 activation
//   w_in       signed Q6.10 weight
//   in_valid   x_in/w_in valid
//   in_ready   block accepts an operand pair
//   acc_out    signed Q10.22 result (meaningful while out_valid=1)
//   out_valid  result valid; held until out_ready
//   out_ready  consumer accepts acc_out
//   busy       a neuron is in progress or its result is pending
//   ovf        sticky overflow flag for the current neuron
// ---------------------------------------------------------------------------
module neuron_mac_q10_22 #(
  parameter int unsigned N_INPUTS = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bias,
  input  logic [15:0] x_in,
  input  logic [15:0] w_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] acc_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] N_CNT  = CNT_W'(N_INPUTS);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_INPUTS - 1);

  state_t state, state_next;

  logic [CNT_W-1:0] issued;      // pairs accepted in this neuron
  logic [CNT_W-1:0] summed;      // products added in this neuron
  logic [31:0]      prod_reg;    // product stage
  logic             prod_valid;  // product stage holds an unsummed term
  logic [31:0]      acc;

  logic        accept;
  logic        do_sum;
  logic        last_sum;
  logic        load;
  logic [31:0] prod_now;
  logic [32:0] sum33;
  logic        sum_ovf;
  logic [31:0] sum_val;

  // -------------------------------------------------------------------------
  // Handshake and control decode
  // -------------------------------------------------------------------------
  assign in_ready  = (state == S_ACC) && (issued < N_CNT);
  assign accept    = in_valid && in_ready;
  assign do_sum    = (state == S_ACC) && prod_valid;
  assign last_sum  = do_sum && (summed == N_LAST);

  // A new neuron may begin from IDLE, or in the same cycle that a DONE result
  // is handed off. Handing off from DONE in that cycle avoids an idle bubble.
  // A start in ACC, or in DONE without out_ready, is ignored.
  assign load = start && ((state == S_IDLE) || ((state == S_DONE) && out_ready));

  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign acc_out   = acc;

  // -------------------------------------------------------------------------
  // Arithmetic
  // -------------------------------------------------------------------------
  // Both operands are sign-extended to 32 bits before the multiply. The full
  // 16x16 signed product always fits in 32 bits, so the low 32 bits are exact.
  assign prod_now = $signed({{16{x_in[15]}}, x_in}) * $signed({{16{w_in[15]}}, w_in});

  // The sum is formed one bit wider so that overflow is visible as
  // disagreement between the two top bits.
  assign sum33   = {acc[31], acc} + {prod_reg[31], prod_reg};
  assign sum_ovf = sum33[32] ^ sum33[31];

`ifdef MAC_SAT_EN
  assign sum_val = !sum_ovf  ? sum33[31:0]   :
                   sum33[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
  assign sum_val = sum33[31:0];
`endif

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  // NOTE: every signal driven in always_comb gets a default on entry. Without
  // that default, any path that skips an assignment would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (load)      state_next = S_ACC;
      S_ACC:  if (last_sum)  state_next = S_DONE;
      S_DONE: if (out_ready) state_next = load ? S_ACC : S_IDLE;
      default:               state_next = S_IDLE;
    endcase
  end

  // NOTE: registers are updated only with non-blocking assignments. Every
  // always_ff block therefore samples the pre-edge values, whatever order the
  // blocks run in.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      issued     <= '0;
      summed     <= '0;
      prod_reg   <= '0;
      prod_valid <= 1'b0;
      ovf        <= 1'b0;
    end else if (load) begin
      acc        <= bias;
      issued     <= '0;
      summed     <= '0;
      prod_valid <= 1'b0;
      ovf        <= 1'b0;
    end else if (state == S_ACC) begin
      // Multiply and accumulate overlap. A term captured on this edge is
      // summed on the next edge, while the previous term is summed now.
      if (accept) begin
        prod_reg <= prod_now;
        issued   <= issued + CNT_W'(1);
      end
      prod_valid <= accept;

      if (do_sum) begin
        acc    <= sum_val;
        summed <= summed + CNT_W'(1);
        if (sum_ovf) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_q10_22.sv
// ---------------------------------------------------------------------------
// Testbench for neuron_mac_q10_22.
// The main instance has N_INPUTS=4. A second instance with N_INPUTS=1
// exercises the single-term neuron.
// Expected values come from hand-derived table constants and from a
// wide-integer reference model of bias + sum(x*w) with saturate/wrap rules.
// ---------------------------------------------------------------------------
module tb_neuron_mac_q10_22;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] bias;
  logic [15:0] x_in;
  logic [15:0] w_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] acc_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        ovf;

  logic        start1;
  logic        in_valid1;
  logic        in_ready1;
  logic [31:0] acc_out1;
  logic        out_valid1;
  logic        out_ready1;
  logic        busy1;
  logic        ovf1;

  always #5 clk = ~clk;

  neuron_mac_q10_22 #(.N_INPUTS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .x_in(x_in), .w_in(w_in),
    .in_valid(in_valid), .in_ready(in_ready), .acc_out(acc_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .ovf(ovf)
  );

  neuron_mac_q10_22 #(.N_INPUTS(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bias(bias), .x_in(x_in), .w_in(w_in),
    .in_valid(in_valid1), .in_ready(in_ready1), .acc_out(acc_out1),
    .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1), .ovf(ovf1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef logic [3:0][15:0] vec_t;  // element [0] is fed first

  typedef struct {
    logic [31:0] b;
    vec_t        xs;
    vec_t        ws;
    logic [31:0] exp_acc;
    logic        exp_ovf;
  } vec_rec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, one term at a time.
  function automatic void model(input logic [31:0] b, input vec_t xs, input vec_t ws,
                                output logic [31:0] r, output logic o);
    longint acc;
    int     bi;
    int     t;
    shortint sx;
    shortint sw;
    bi  = b;
    acc = bi;
    o   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sx  = xs[i];
      sw  = ws[i];
      acc = acc + longint'(sx) * longint'(sw);
      if (acc > 64'sd2147483647 || acc < -64'sd2147483648) begin
        o = 1'b1;
`ifdef MAC_SAT_EN
        acc = (acc > 0) ? 64'sd2147483647 : -64'sd2147483648;
`else
        t   = int'(acc);
        acc = t;
`endif
      end
    end
    r = acc[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_neuron(input logic [31:0] b);
    bias  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_in_ready", in_ready, 1);
  endtask

  // Feeds the first n pairs and returns just after the last accepting edge.
  task automatic feed(input vec_t xs, input vec_t ws, input bit gaps, input int n);
    int  i   = 0;
    int  cyc = 0;
    logic took;
    while (i < n && cyc < 40) begin
      in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      x_in     = xs[i];
      w_in     = ws[i];
      took     = in_valid && in_ready;
      tick();
      if (took) i++;
      cyc++;
    end
    in_valid = 1'b0;
    if (i < n) check("feed_timeout", i, n);
  endtask

  // The result appears one edge after the last accepting edge. The bench
  // checks that acc_out and ovf then hold through a stall. In poke mode it
  // also drives in_valid during DONE, which the block must ignore.
  task automatic finish_neuron(input int stall, input bit poke,
                               output logic [31:0] got, output logic got_ovf);
    check("valid_before_sum", out_valid, 0);
    tick();
    check("valid_latency", out_valid, 1);
    check("done_in_ready", in_ready, 0);
    got     = acc_out;
    got_ovf = ovf;
    if (poke) begin
      in_valid = 1'b1;
      x_in     = 16'h7FFF;
      w_in     = 16'h7FFF;
    end
    for (int k = 0; k < stall; k++) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_acc", acc_out, got);
      check("stall_ovf", ovf, got_ovf);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic run_neuron(input logic [31:0] b, input vec_t xs, input vec_t ws,
                            input bit gaps, input int stall, input bit poke,
                            output logic [31:0] got, output logic got_ovf);
    start_neuron(b);
    feed(xs, ws, gaps, 4);
    finish_neuron(stall, poke, got, got_ovf);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_rec_t    tbl[6];
    logic [31:0] got;
    logic        got_ovf;
    logic [31:0] exp;
    logic        exp_o;
    vec_t        xs;
    vec_t        ws;
    vec_t        t1x;
    vec_t        t1w;

    rst = 1'b1; start = 1'b0; bias = '0; x_in = '0; w_in = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    start1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    t1x = {4{16'h1000}};
    t1w = {4{16'h0400}};

    tick();
    tick();
    check("rst_acc", acc_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    in_valid = 1'b1;
    tick();
    check("idle_ignores_in_valid", in_ready, 0);
    in_valid = 1'b0;

    // ----- table-driven vectors -----
    tbl[0] = '{32'h0, t1x, t1w, 32'h0100_0000, 1'b0};                         // 4 x 1.0
    tbl[1] = '{32'h0040_0000, {4{16'hF000}}, t1w, 32'hFF40_0000, 1'b0};       // 1 - 4 = -3.0
    tbl[2] = '{32'h0, {4{16'h2000}}, {4{16'hFC00}}, 32'hFE00_0000, 1'b0};     // 4 x -2.0
`ifdef MAC_SAT_EN
    tbl[3] = '{32'h0, {4{16'h7FFF}}, {4{16'h7FFF}}, 32'h7FFF_FFFF, 1'b1};
    tbl[4] = '{32'h0, {4{16'h8000}}, {4{16'h7FFF}}, 32'h8000_0000, 1'b1};
    // saturated value stays the base: 0x7FFFFFFF + 0xC0008000
    tbl[5] = '{32'h0, {16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF}, {4{16'h7FFF}}, 32'h4000_7FFF, 1'b1};
`else
    tbl[3] = '{32'h0, {4{16'h7FFF}}, {4{16'h7FFF}}, 32'hFFFC_0004, 1'b1};
    tbl[4] = '{32'h0, {4{16'h8000}}, {4{16'h7FFF}}, 32'h0002_0000, 1'b1};
    tbl[5] = '{32'h0, {16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF}, {4{16'h7FFF}}, 32'h7FFD_8003, 1'b1};
`endif
    for (int i = 0; i < 6; i++) begin
      run_neuron(tbl[i].b, tbl[i].xs, tbl[i].ws, 1'b0, 0, 1'b0, got, got_ovf);
      check($sformatf("tbl%0d_acc", i), got, tbl[i].exp_acc);
      check($sformatf("tbl%0d_ovf", i), got_ovf, tbl[i].exp_ovf);
    end

    // ----- T4: input gaps, 5-cycle output stall, in_valid poked during DONE -----
    run_neuron(32'h0, t1x, t1w, 1'b1, 5, 1'b1, got, got_ovf);
    check("t4_acc", got, 32'h0100_0000);
    check("t4_ovf", got_ovf, 0);

    // ----- T5: reset after 2 of 4 pairs, then a fresh neuron -----
    start_neuron(32'h0);
    feed(t1x, t1w, 1'b0, 2);
    rst = 1'b1;
    tick();
    check("t5_acc", acc_out, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 0);
    check("t5_busy", busy, 0);
    check("t5_ovf", ovf, 0);
    rst = 1'b0;
    tick();
    check("t5_no_output", out_valid, 0);
    run_neuron(32'h0, t1x, t1w, 1'b0, 0, 1'b0, got, got_ovf);
    check("t5_fresh_acc", got, 32'h0100_0000);

    // ----- T6: start on the handoff cycle, no idle bubble -----
    start_neuron(32'h0);
    feed(t1x, t1w, 1'b0, 4);
    tick();
    check("t6_first_valid", out_valid, 1);
    check("t6_first_acc", acc_out, 32'h0100_0000);
    out_ready = 1'b1;
    start     = 1'b1;
    bias      = 32'h0040_0000;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check("t6_busy", busy, 1);
    check("t6_in_ready", in_ready, 1);
    check("t6_valid_cleared", out_valid, 0);
    feed(t1x, t1w, 1'b0, 4);
    finish_neuron(0, 1'b0, got, got_ovf);
    check("t6_second_acc", got, 32'h0140_0000);

    // ----- N_INPUTS = 1 -----
    bias   = 32'h0040_0000;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("n1_in_ready", in_ready1, 1);
    in_valid1 = 1'b1;
    x_in      = 16'h1000;
    w_in      = 16'h0400;
    tick();
    in_valid1 = 1'b0;
    check("n1_valid_early", out_valid1, 0);
    check("n1_in_ready_after", in_ready1, 0);
    tick();
    check("n1_valid", out_valid1, 1);
    check("n1_acc", acc_out1, 32'h0080_0000);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("n1_idle", busy1, 0);

    // ----- randomized neurons against the reference model -----
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (n % 3 == 0) begin
          xs[i] = 16'($urandom);
          ws[i] = 16'($urandom);
        end else begin
          xs[i] = 16'($urandom_range(0, 8191)) - 16'd4096;
          ws[i] = 16'($urandom_range(0, 4095)) - 16'd2048;
        end
      end
      bias = (n % 2 == 0) ? $urandom : 32'($urandom_range(0, 32'h0100_0000)) - 32'h0080_0000;
      model(bias, xs, ws, exp, exp_o);
      run_neuron(bias, xs, ws, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0,
                 got, got_ovf);
      check($sformatf("rand%0d_acc", n), got, exp);
      check($sformatf("rand%0d_ovf", n), got_ovf, exp_o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
